fu_pipe_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a shared, fixed-latency, N-stage pipelined functional unit, for example the multi-cycle multiplier built from enable-gated register stages. It grants one request per cycle with round-robin fairness. It drives the datapath stage enable and operand select, and carries valid, source and destination-tag sideband through N stages aligned with the datapath. It back-pressures on a blocked result and supports flush on branch mispredict or exception.

---
 rtl/fu_pipe_arbiter.sv | 84 ++++++++
 tb/tb_fu_pipe_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fu_pipe_arbiter.sv
// rtl/fu_pipe_arbiter.sv - round-robin two-requester arbiter and sideband sequencer for an N-stage pipelined unit
module fu_pipe_arbiter #(
  parameter int N     = 5,
  parameter int TAG_W = 5,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  input  logic             flush,
  output logic             pipe_enable,
  output logic             pipe_sel,
  output logic             out_valid,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy
);

  // Sideband stages shift toward index N-1, which faces the consumer.
  logic [N-1:0]            stage_valid;
  logic [N-1:0]            stage_src;
  logic [N-1:0][TAG_W-1:0] stage_tag;
  logic                    rr;
  logic [CNT_W-1:0]        occ;

  logic             stall;
  logic             can_grant;
  logic             grant0;
  logic             grant1;
  logic             grant_any;
  logic [TAG_W-1:0] grant_tag;
  logic             consumed;

  assign out_valid   = stage_valid[N-1];
  assign out_src     = stage_src[N-1];
  assign out_tag     = stage_tag[N-1];
  assign stall       = out_valid & ~out_ready;
  assign pipe_enable = ~stall;
  assign can_grant   = ~stall & ~flush;

  // rr only matters on contention; a lone requester always wins.
  assign grant0    = can_grant & req0_valid & (~req1_valid | ~rr);
  assign grant1    = can_grant & req1_valid & (~req0_valid | rr);
  assign grant_any = grant0 | grant1;
  assign grant_tag = grant1 ? req1_tag : req0_tag;

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign pipe_sel   = grant_any ? grant1 : rr;

  assign consumed  = out_valid & out_ready;
  assign occupancy = occ;
  assign busy      = (occ != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
      stage_src   <= '0;
      stage_tag   <= '0;
      rr          <= 1'b0;
      occ         <= '0;
    end else if (flush) begin
      // Flush wins over stall; src/tag are left stale since valid gates them.
      stage_valid <= '0;
      occ         <= '0;
    end else if (!stall) begin
      stage_valid <= {stage_valid[N-2:0], grant_any};
      stage_src   <= {stage_src[N-2:0], grant1};
      stage_tag   <= {stage_tag[N-2:0], grant_tag};
      if (grant_any) begin
        rr <= ~grant1;
      end
      occ <= occ + CNT_W'(grant_any) - CNT_W'(consumed);
    end
  end

endmodule

// File: tb/tb_fu_pipe_arbiter.sv
// tb/tb_fu_pipe_arbiter.sv - scoreboard bench for fu_pipe_arbiter with a transaction-level reference model
module tb_fu_pipe_arbiter;
  localparam int N     = 5;
  localparam int TAG_W = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             req0_ready, req1_ready;
  logic             flush;
  logic             pipe_enable, pipe_sel;
  logic             out_valid, out_src;
  logic [TAG_W-1:0] out_tag;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  // Model: each in-flight op is just its number of advances since acceptance.
  int               ages[$];
  logic [TAG_W:0]   exp_q[$];
  logic             m_rr;

  fu_pipe_arbiter #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .flush(flush), .pipe_enable(pipe_enable), .pipe_sel(pipe_sel),
    .out_valid(out_valid), .out_src(out_src), .out_tag(out_tag),
    .out_ready(out_ready), .busy(busy), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    ages.delete();
    exp_q.delete();
    m_rr = 1'b0;
  endtask

  task automatic drv(input bit a, input int ta, input bit b, input int tb2,
                     input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    req0_valid = a;
    req0_tag   = TAG_W'(ta);
    req1_valid = b;
    req1_tag   = TAG_W'(tb2);
    out_ready  = ordy;
    flush      = fl;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a result.
  always @(negedge clk) begin
    #1;
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        logic [TAG_W:0] e;
        e = exp_q.pop_front();
        check("out_src", int'(out_src), int'(e[TAG_W]));
        check("out_tag", int'(out_tag), int'(e[TAG_W-1:0]));
      end
    end
  end

  // Reference model: predicts arbitration and timing from the rules, then advances.
  always @(negedge clk) begin
    #3;
    if (reset) begin
      bit head_out, stall, can, g0, g1;
      int exp_sel;
      head_out = (ages.size() > 0) && (ages[0] == N);
      stall    = head_out && !out_ready;
      can      = !stall && !flush;
      g0 = can && req0_valid && (!req1_valid || m_rr == 1'b0);
      g1 = can && req1_valid && (!req0_valid || m_rr == 1'b1);
      exp_sel = g1 ? 1 : (g0 ? 0 : int'(m_rr));
      check("out_valid",   int'(out_valid),   int'(head_out));
      check("req0_ready",  int'(req0_ready),  int'(g0));
      check("req1_ready",  int'(req1_ready),  int'(g1));
      check("pipe_enable", int'(pipe_enable), int'(!stall));
      check("pipe_sel",    int'(pipe_sel),    exp_sel);
      check("occupancy",   int'(occupancy),   ages.size());
      check("busy",        int'(busy),        int'(ages.size() != 0));
      if (flush) begin
        ages.delete();
        exp_q.delete();
      end else if (!stall) begin
        if (head_out) void'(ages.pop_front());
        foreach (ages[i]) ages[i]++;
        if (g0 || g1) begin
          ages.push_back(1);
          exp_q.push_back({g1, g1 ? req1_tag : req0_tag});
          m_rr = !g1;
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_tag = '0; req1_tag = '0;
    out_ready = 1; flush = 0;
    model_clear();
    #3;
    check("rst_out_valid",   int'(out_valid),   0);
    check("rst_busy",        int'(busy),        0);
    check("rst_occupancy",   int'(occupancy),   0);
    check("rst_pipe_enable", int'(pipe_enable), 1);
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;

    // Single op: result exactly N cycles after acceptance.
    drv(1, 7, 0, 0, 1, 0);
    for (int k = 1; k <= N + 1; k++) begin
      drv(0, 0, 0, 0, 1, 0);
      #3;
      check("latency_out_valid", int'(out_valid), int'(k == N));
      if (k == N) check("latency_out_tag", int'(out_tag), 7);
    end

    // Contention: alternating grants, then drain.
    for (int k = 0; k < 4; k++) drv(1, 1, 1, 2, 1, 0);
    for (int k = 0; k < N + 2; k++) drv(0, 0, 0, 0, 1, 0);

    // Fill, stall for 3 cycles with both requesting, release.
    for (int k = 0; k < N; k++) drv(1, 10 + k, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drv(1, 3, 1, 4, 0, 0);
    for (int k = 0; k < N + 3; k++) drv(0, 0, 0, 0, 1, 0);

    // Flush while stalled with 3 in flight and req0 pending.
    for (int k = 0; k < 3; k++) drv(1, 20 + k, 0, 0, 0, 0);
    for (int k = 0; k < N; k++) drv(0, 0, 0, 0, 0, 0);
    drv(1, 9, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 0);
    #3;
    check("post_flush_occupancy", int'(occupancy), 0);
    check("post_flush_out_valid", int'(out_valid), 0);

    // Asynchronous reset with 2 in flight; readies still follow rr = 0.
    drv(1, 5, 0, 0, 1, 0);
    drv(0, 0, 1, 6, 1, 0);
    drv(1, 1, 1, 2, 1, 0);
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    check("async_out_valid",   int'(out_valid),   0);
    check("async_occupancy",   int'(occupancy),   0);
    check("async_busy",        int'(busy),        0);
    check("async_out_tag",     int'(out_tag),     0);
    check("async_pipe_enable", int'(pipe_enable), 1);
    check("async_req0_ready",  int'(req0_ready),  1);
    check("async_req1_ready",  int'(req1_ready),  0);
    @(posedge clk);
    #2 reset = 1'b1;
    drv(0, 0, 1, 12, 1, 0);

    // Bubble preserved between two ops.
    drv(1, 3, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1, 0);
    drv(0, 0, 1, 4, 1, 0);
    for (int k = 0; k < N + 3; k++) drv(0, 0, 0, 0, 1, 0);

    // Randomized traffic with occasional back-pressure and flush.
    for (int k = 0; k < 800; k++)
      drv($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
          $urandom_range(0, 31), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    for (int k = 0; k < N + 4; k++) drv(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #4;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
